btn_event_decoder: RTL and testbench
====================================

# btn_event_decoder

Parametrised, N-channel button front end that replaces the fixed debouncer feeding the metronome core. Each raw, asynchronous button input is synchronised, debounced and classified into short-press, long-press and auto-repeat events, which drive the metronome ±1 / ±5 / ±5-hold controls. All channels are identical and fully independent, running on the system PLL clock.

## Interface
- N_BTNS, 4: number of independent button channels (≥1).
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised input must differ from the debounced level before the level flips (≥1).
- LONG_CYCLES, 25000000: cycles a debounced press must last to count as long (≥1).
- REPEAT_CYCLES, 10000000: auto-repeat period after the long event while still held (≥1).
- ACTIVE_LOW, 0: 1 = raw inputs are active-low and are inverted before synchronisation.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_btn  in  N_BTNS  raw, asynchronous button inputs.
- o_level  out  N_BTNS  debounced level (1 = pressed).
- o_short  out  N_BTNS  1-cycle pulse on release of a press shorter than LONG_CYCLES.
- o_long  out  N_BTNS  1-cycle pulse when a press reaches LONG_CYCLES.
- o_repeat  out  N_BTNS  1-cycle pulse every REPEAT_CYCLES after o_long while held.
- o_held  out  N_BTNS  level, high from o_long until release.

## Operation
- Per channel: polarity fix (ACTIVE_LOW) -> 2-flop synchroniser -> debounce counter -> classification FSM. Channels share no state.
- Debounce: counter clears whenever sync output equals o_level; otherwise it increments. When it would reach DEBOUNCE_CYCLES, o_level toggles and the counter clears. A glitch shorter than DEBOUNCE_CYCLES never changes o_level.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE: wait for o_level rise -> PRESSED, hold counter = 0.
  - PRESSED: counter increments each cycle. Level falls -> pulse o_short, go to IDLE. Counter reaches LONG_CYCLES -> pulse o_long, raise o_held, clear the repeat counter, go to HELD.
  - HELD: repeat counter increments. On reaching REPEAT_CYCLES it pulses o_repeat and clears. Level falls -> drop o_held, go to IDLE. No o_short and no o_repeat on release.
- Counter widths are $clog2(max+1) of their respective parameters. Counters never wrap: every count is cleared on a state change, so an arbitrarily long hold yields periodic o_repeat with no overflow.
- Simultaneous events on different channels: each pulses in the same cycle with no arbitration.
- Reset (asynchronous assert, any time including mid-press): all synchronisers, counters and outputs go to 0 and the FSM goes to IDLE. A button held through reset is seen as a new press once reset is released and the debounce completes.

## Timing
- Reset values: o_level, o_short, o_long, o_repeat and o_held are all 0.
- Let edge 0 be the first clock edge that samples a new raw value that then stays stable. o_level changes after edge DEBOUNCE_CYCLES+1.
- Let edge t be the edge at which o_level rises.
  - o_long is high in the cycle after edge t+LONG_CYCLES, and o_held rises in the same cycle.
  - o_repeat is high in the cycle after edge t+LONG_CYCLES+k·REPEAT_CYCLES, for k≥1.
- o_short is high for exactly the first cycle in which o_level reads 0 after a press that ended in PRESSED.
- o_held falls in the same cycle that o_level falls.
- All outputs are registered; no combinational path from i_btn to any output.

## Test plan
Test parameters: N_BTNS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=0.
- Glitch rejection: pulse i_btn[0] high for 3 cycles, repeated 10 times with 2-cycle gaps -> o_level[0] stays 0 and no event pulses.
- Short press: hold i_btn[1] for 12 cycles -> o_level[1] rises after edge 5 and falls 12 cycles later. Exactly one o_short[1] pulse in the first low cycle. o_long, o_repeat and o_held stay 0.
- Long press with repeat: hold i_btn[2] for 60 cycles after the o_level rise at edge t -> o_long at t+20, o_repeat at t+28, t+36, t+44, t+52. o_held is high from t+20 until o_level falls. No o_short.
- Simultaneous: press all 4 channels on the same edge for 30 cycles -> identical pulses on all channels in the same cycles (o_long at t+20, o_repeat at t+28).
- Reset mid-press: assert i_reset_n=0 while channel 2 is in HELD -> all outputs are 0 immediately. Release reset with the button still held -> o_level rises 5 edges later, and o_long follows 20 cycles after that.
- ACTIVE_LOW=1: drive i_btn=4'b1111 idle, then hold 4'b1110 for 12 cycles -> o_short[0] only.

Source files
------------

// File: rtl/btn_event_decoder.sv
// N-channel button front end: polarity fix, 2-flop synchroniser, debounce and a
// per-channel press classifier producing short, long, auto-repeat and held outputs.
module btn_event_decoder #(
  parameter int N_BTNS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [N_BTNS-1:0] i_btn,
  output logic [N_BTNS-1:0] o_level,
  output logic [N_BTNS-1:0] o_short,
  output logic [N_BTNS-1:0] o_long,
  output logic [N_BTNS-1:0] o_repeat,
  output logic [N_BTNS-1:0] o_held
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LG_W = $clog2(LONG_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

  // Terminal values: the event fires on the cycle the count would reach the parameter.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic [N_BTNS-1:0] btn_in;
  assign btn_in = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

  for (genvar g = 0; g < N_BTNS; g++) begin : g_ch
    logic [1:0]      sync_q, sync_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    state_t          state_q, state_d;
    logic [LG_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;
    logic            held_q, held_d;

    always_comb begin
      sync_d   = {sync_q[0], btn_in[g]};
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      if (sync_q[1] == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        level_d  = ~level_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Classifier acts on the new debounced level so events line up with o_level edges.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      short_d    = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      held_d     = held_q;
      case (state_q)
        IDLE: begin
          if (level_d) begin
            state_d    = PRESSED;
            hold_cnt_d = '0;
          end
        end
        PRESSED: begin
          if (!level_d) begin
            short_d    = 1'b1;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end else if (hold_cnt_q == LG_LAST) begin
            long_d     = 1'b1;
            held_d     = 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            state_d    = HELD;
          end else begin
            hold_cnt_d = hold_cnt_q + LG_W'(1);
          end
        end
        HELD: begin
          // Release wins over a coincident repeat tick.
          if (!level_d) begin
            held_d    = 1'b0;
            rep_cnt_d = '0;
            state_d   = IDLE;
          end else if (rep_cnt_q == RP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + RP_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          held_d  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        sync_q     <= '0;
        db_cnt_q   <= '0;
        level_q    <= 1'b0;
        state_q    <= IDLE;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        short_q    <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
        held_q     <= 1'b0;
      end else begin
        sync_q     <= sync_d;
        db_cnt_q   <= db_cnt_d;
        level_q    <= level_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        short_q    <= short_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
        held_q     <= held_d;
      end
    end

    assign o_level[g]  = level_q;
    assign o_short[g]  = short_q;
    assign o_long[g]   = long_q;
    assign o_repeat[g] = repeat_q;
    assign o_held[g]   = held_q;
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: vector table, hand-written timing sequences and
// random stimulus compared every cycle against an elapsed-time reference model.
module tb_btn_event_decoder;
  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn, btn_al;
  logic [N-1:0] o_level, o_short, o_long, o_repeat, o_held;
  logic [N-1:0] al_level, al_short, al_long, al_repeat, al_held;

  always #5 clk = ~clk;

  btn_event_decoder #(.N_BTNS(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG),
                      .REPEAT_CYCLES(REP), .ACTIVE_LOW(0)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn),
    .o_level(o_level), .o_short(o_short), .o_long(o_long),
    .o_repeat(o_repeat), .o_held(o_held));

  btn_event_decoder #(.N_BTNS(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG),
                      .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)) u_dut_al (
    .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn_al),
    .o_level(al_level), .o_short(al_short), .o_long(al_long),
    .o_repeat(al_repeat), .o_held(al_held));

  // Reference model: level follows a run-length rule on the 2-cycle delayed input;
  // events derive from the number of edges elapsed since the level rose.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_short, m_long, m_rep, m_held;
  logic [N-1:0] m_s1_n, m_s2_n, m_lvl_n, m_short_n, m_long_n, m_rep_n, m_held_n;
  int m_run[N], m_age[N], m_run_n[N], m_age_n[N];

  always_comb begin
    m_s1_n = btn;
    m_s2_n = m_s1;
    m_lvl_n = m_lvl;
    m_short_n = '0;
    m_long_n = '0;
    m_rep_n = '0;
    m_held_n = '0;
    m_run_n = m_run;
    m_age_n = m_age;
    for (int c = 0; c < N; c++) begin
      if (m_s2[c] != m_lvl[c]) begin
        m_run_n[c] = m_run[c] + 1;
        if (m_run_n[c] >= DEB) begin
          m_lvl_n[c] = ~m_lvl[c];
          m_run_n[c] = 0;
        end
      end else begin
        m_run_n[c] = 0;
      end
      if (m_lvl_n[c] && !m_lvl[c]) begin
        m_age_n[c] = 0;
      end else if (m_lvl_n[c]) begin
        m_age_n[c] = m_age[c] + 1;
        m_long_n[c] = (m_age_n[c] == LNG);
        m_rep_n[c] = (m_age_n[c] > LNG) && (((m_age_n[c] - LNG) % REP) == 0);
      end else if (m_lvl[c]) begin
        m_short_n[c] = ((m_age[c] + 1) <= LNG);
      end
      m_held_n[c] = m_lvl_n[c] && (m_age_n[c] >= LNG);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0;
      m_short <= '0; m_long <= '0; m_rep <= '0; m_held <= '0;
      for (int c = 0; c < N; c++) begin
        m_run[c] <= 0;
        m_age[c] <= 0;
      end
    end else begin
      m_s1 <= m_s1_n; m_s2 <= m_s2_n; m_lvl <= m_lvl_n;
      m_short <= m_short_n; m_long <= m_long_n; m_rep <= m_rep_n; m_held <= m_held_n;
      m_run <= m_run_n;
      m_age <= m_age_n;
    end
  end

  int n_checks = 0;
  int n_fails = 0;
  int cyc = 0;
  int tot_short[N], tot_long[N], tot_rep[N], tot_lvl[N];
  int al_tot_short[N], al_tot_other[N];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    n_checks++;
    if ({o_level, o_short, o_long, o_repeat, o_held} !== {m_lvl, m_short, m_long, m_rep, m_held}) begin
      n_fails++;
      $display("FAIL model cycle %0d: got lvl=%b sh=%b lg=%b rp=%b hd=%b expected lvl=%b sh=%b lg=%b rp=%b hd=%b",
               cyc, o_level, o_short, o_long, o_repeat, o_held, m_lvl, m_short, m_long, m_rep, m_held);
    end
    for (int c = 0; c < N; c++) begin
      tot_short[c] += int'(o_short[c]);
      tot_long[c]  += int'(o_long[c]);
      tot_rep[c]   += int'(o_repeat[c]);
      tot_lvl[c]   += int'(o_level[c]);
      al_tot_short[c] += int'(al_short[c]);
      al_tot_other[c] += int'(al_long[c]) + int'(al_repeat[c]) + int'(al_held[c]) + int'(al_level[c]);
    end
  endtask

  // kind: 0 level, 1 long, 2 repeat, 3 held. Returns -1 if the bound expires.
  task automatic wait_for(input int ch, input int kind, input logic val, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      logic v;
      step();
      case (kind)
        0: v = o_level[ch];
        1: v = o_long[ch];
        2: v = o_repeat[ch];
        default: v = o_held[ch];
      endcase
      if (v === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int hold;
    int e_short;
    int e_long;
    int e_rep;
  } vec_t;

  vec_t vt[8];
  int rem[N];

  initial begin
    int s0[N], l0[N], r0[N], v0[N], a0[N], o0[N];
    int t, at, at2;

    vt[0] = '{4'b0001,  3, 0, 0, 0};
    vt[1] = '{4'b0010,  4, 1, 0, 0};
    vt[2] = '{4'b0010, 12, 1, 0, 0};
    vt[3] = '{4'b0100, 21, 0, 1, 0};
    vt[4] = '{4'b1000, 28, 0, 1, 0};
    vt[5] = '{4'b0001, 29, 0, 1, 1};
    vt[6] = '{4'b0100, 60, 0, 1, 4};
    vt[7] = '{4'b1111, 30, 0, 1, 1};

    for (int c = 0; c < N; c++) begin
      tot_short[c] = 0; tot_long[c] = 0; tot_rep[c] = 0; tot_lvl[c] = 0;
      al_tot_short[c] = 0; al_tot_other[c] = 0;
    end

    rst_n = 1'b0;
    btn = '0;
    btn_al = '1;
    step();
    step();
    check("reset_outputs", int'({o_level, o_short, o_long, o_repeat, o_held}), 0);
    check("reset_outputs_al", int'({al_level, al_short, al_long, al_repeat, al_held}), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Table-driven presses
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < N; c++) begin
        s0[c] = tot_short[c]; l0[c] = tot_long[c]; r0[c] = tot_rep[c];
      end
      btn = vt[v].mask;
      for (int i = 0; i < vt[v].hold; i++) step();
      btn = '0;
      for (int i = 0; i < 20; i++) step();
      for (int c = 0; c < N; c++) begin
        check($sformatf("vec%0d_ch%0d_short", v, c), tot_short[c] - s0[c], vt[v].mask[c] ? vt[v].e_short : 0);
        check($sformatf("vec%0d_ch%0d_long", v, c), tot_long[c] - l0[c], vt[v].mask[c] ? vt[v].e_long : 0);
        check($sformatf("vec%0d_ch%0d_repeat", v, c), tot_rep[c] - r0[c], vt[v].mask[c] ? vt[v].e_rep : 0);
      end
    end

    // Glitch train on channel 0
    for (int c = 0; c < N; c++) begin
      s0[c] = tot_short[c]; l0[c] = tot_long[c]; r0[c] = tot_rep[c]; v0[c] = tot_lvl[c];
    end
    for (int k = 0; k < 10; k++) begin
      btn[0] = 1'b1;
      for (int i = 0; i < 3; i++) step();
      btn[0] = 1'b0;
      for (int i = 0; i < 2; i++) step();
    end
    for (int i = 0; i < 10; i++) step();
    check("glitch_level", tot_lvl[0] - v0[0], 0);
    check("glitch_events", (tot_short[0] - s0[0]) + (tot_long[0] - l0[0]) + (tot_rep[0] - r0[0]), 0);

    // Long press timing on channel 2
    btn = 4'b0100;
    t = cyc;
    wait_for(2, 0, 1'b1, at);
    check("long_level_rise_delay", at - t, DEB + 2);
    t = at;
    wait_for(2, 1, 1'b1, at);
    check("long_pulse_delay", at - t, LNG);
    check("held_with_long", int'(o_held[2]), 1);
    wait_for(2, 2, 1'b1, at2);
    check("repeat1_delay", at2 - at, REP);
    wait_for(2, 2, 1'b1, at);
    check("repeat2_delay", at - at2, REP);
    check("held_during_repeat", int'(o_held[2]), 1);
    btn = '0;
    wait_for(2, 0, 1'b0, at);
    check("held_falls_with_level", int'(o_held[2]), 0);
    check("no_short_after_long", int'(o_short[2]), 0);
    for (int i = 0; i < 5; i++) step();

    // Reset while channel 2 is held, button kept down through reset
    btn = 4'b0100;
    wait_for(2, 3, 1'b1, at);
    check("held_before_reset", int'(o_held[2]), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", int'({o_level, o_short, o_long, o_repeat, o_held}), 0);
    step();
    rst_n = 1'b1;
    t = cyc;
    wait_for(2, 0, 1'b1, at);
    check("post_reset_level_delay", at - t, DEB + 2);
    t = at;
    wait_for(2, 1, 1'b1, at);
    check("post_reset_long_delay", at - t, LNG);
    btn = '0;
    for (int i = 0; i < 15; i++) step();

    // Active-low instance: only channel 0 pressed (driven low)
    for (int c = 0; c < N; c++) begin
      a0[c] = al_tot_short[c]; o0[c] = al_tot_other[c];
    end
    btn_al = 4'b1110;
    for (int i = 0; i < 12; i++) step();
    btn_al = 4'b1111;
    for (int i = 0; i < 20; i++) step();
    for (int c = 0; c < N; c++)
      check($sformatf("al_ch%0d_short", c), al_tot_short[c] - a0[c], (c == 0) ? 1 : 0);
    check("al_ch0_no_long_repeat_held", al_tot_other[0] - o0[0] - (DEB == 4 ? 12 : 0), 0);
    check("al_others_idle", (al_tot_other[1] - o0[1]) + (al_tot_other[2] - o0[2]) + (al_tot_other[3] - o0[3]), 0);

    // Randomised independent channels against the model
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          btn[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 70)) : int'($urandom_range(1, 12));
        end
        rem[c]--;
      end
      step();
    end
    btn = '0;
    for (int i = 0; i < 30; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
